// File: rtl/positron_layer_sequencer_pkg.sv
// posit_defines: shared state encoding and helper functions for the positron layer sequencer
package posit_defines;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, EMIT} seq_state_t;

    function automatic int log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic [63:0] nar(input int width);
        return 64'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/positron_layer_sequencer_skid_fifo.sv
// seq_skid_fifo: 2-entry valid/ready FIFO carrying a posit beat with its sow/eow flags
module seq_skid_fifo #(
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] mem [2];
    logic          wp, rp;
    logic [1:0]    cnt;
    logic          push, pop;

    assign in_ready  = cnt != 2'd2;
    assign out_valid = cnt != 2'd0;
    assign out_data  = mem[rp];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ping-pong storage with occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) mem[wp] <= in_data;
            wp  <= push ? ~wp : wp;
            rp  <= pop ? ~rp : rp;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/positron_layer_sequencer.sv
// positron_layer_sequencer: broadcasts one activation frame to a positron array and serializes the results; SEQ_TIMEOUT_EN adds a drain watchdog
module positron_layer_sequencer
    import posit_defines::*;
#(
    parameter int POSIT_WIDTH          = 4,
    parameter int NB_UPSTREAM_POSITRON = 784,
    parameter int NB_POSITRON          = 16,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [log2(NB_UPSTREAM_POSITRON)-1:0] act_addr_o,
    output logic                                  act_rd_en_o,
    input  logic [POSIT_WIDTH-1:0]                act_data_i,
    output logic                                  pos_rts_o,
    output logic                                  pos_sow_o,
    output logic                                  pos_eow_o,
    output logic [POSIT_WIDTH-1:0]                pos_posit_o,
    input  logic [NB_POSITRON-1:0]                pos_rtr_i,
    output logic                                  pos_rtr_o,
    input  logic [NB_POSITRON-1:0]                pos_rts_i,
    input  logic [NB_POSITRON*POSIT_WIDTH-1:0]    pos_posit_i,
    output logic                                  rts_o,
    input  logic                                  rtr_i,
    output logic                                  eow_o,
    output logic [log2(NB_POSITRON)-1:0]          index_o,
    output logic [POSIT_WIDTH-1:0]                posit_o,
    output logic                                  error_o
);

    localparam int W  = POSIT_WIDTH;
    localparam int AW = log2(NB_UPSTREAM_POSITRON);
    localparam int IW = log2(NB_POSITRON);
    localparam int CW = $clog2(NB_UPSTREAM_POSITRON + 1);
    localparam logic [CW-1:0] NB_RD   = CW'(NB_UPSTREAM_POSITRON);
    localparam logic [CW-1:0] LAST_RD = CW'(NB_UPSTREAM_POSITRON - 1);
    localparam logic [IW-1:0] LAST_EM = IW'(NB_POSITRON - 1);

    seq_state_t             state;
    logic [CW-1:0]          rd_cnt;
    logic                   rd_q, rd_sow_q, rd_eow_q, rd_go;
    logic [2:0]             occ;
    logic [1:0]             f_cnt;
    logic                   f_in_ready, f_valid, f_ready, beat_acc;
    logic [W+1:0]           f_data;
    logic [IW-1:0]          em_cnt;
    logic [NB_POSITRON-1:0] cap_v;
    logic [W-1:0]           cap [NB_POSITRON];
    logic                   timeout;
    logic [W-1:0]           fill_val;

    assign f_ready  = (state == STREAM) && (&pos_rtr_i);
    assign beat_acc = f_valid && f_ready;
    assign f_cnt    = !f_in_ready ? 2'd2 : {1'b0, f_valid};
    assign occ      = 3'(f_cnt) + 3'(rd_q) - 3'(beat_acc);
    assign rd_go    = (state == STREAM || (state == IDLE && start_i)) && rd_cnt < NB_RD && occ < 3'd2;

    assign act_rd_en_o = rd_go;
    assign act_addr_o  = rd_go ? rd_cnt[AW-1:0] : '0;
    assign pos_rts_o   = f_valid;
    assign pos_sow_o   = f_valid && f_data[W+1];
    assign pos_eow_o   = f_valid && f_data[W];
    assign pos_posit_o = f_valid ? f_data[W-1:0] : '0;
    assign pos_rtr_o   = state == DRAIN;
    assign busy_o      = state != IDLE;
    assign rts_o       = state == EMIT;
    assign eow_o       = rts_o && em_cnt == LAST_EM;
    assign index_o     = em_cnt;
    assign posit_o     = rts_o ? cap[em_cnt] : '0;

    seq_skid_fifo #(.DW(W + 2)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_q),
        .in_ready  (f_in_ready),
        .in_data   ({rd_sow_q, rd_eow_q, act_data_i}),
        .out_valid (f_valid),
        .out_ready (f_ready),
        .out_data  (f_data)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wd_cnt;
    logic          err_q;
    assign timeout  = state == DRAIN && !(&cap_v) && wd_cnt == TO_LAST;
    assign fill_val = W'(nar(W));
    assign error_o  = err_q;
    // watchdog counts DRAIN cycles from zero on every DRAIN entry; error is sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= state == DRAIN ? wd_cnt + TW'(1) : '0;
            err_q  <= err_q || timeout;
        end
    end
`else
    assign timeout  = 1'b0;
    assign fill_val = '0;
    assign error_o  = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    // sequencer FSM with read pipeline, result capture and emit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            rd_q     <= 1'b0;
            rd_sow_q <= 1'b0;
            rd_eow_q <= 1'b0;
            em_cnt   <= '0;
            cap_v    <= '0;
            done_o   <= 1'b0;
            for (int k = 0; k < NB_POSITRON; k++) cap[k] <= '0;
        end else begin
            rd_q     <= rd_go;
            rd_sow_q <= rd_cnt == '0;
            rd_eow_q <= rd_cnt == LAST_RD;
            rd_cnt   <= rd_go ? rd_cnt + CW'(1) : rd_cnt;
            done_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= STREAM;
                        cap_v <= '0;
                    end
                end
                STREAM: begin
                    if (beat_acc && f_data[W]) begin
                        state  <= DRAIN;
                        rd_cnt <= '0;
                    end
                end
                DRAIN: begin
                    for (int k = 0; k < NB_POSITRON; k++) begin
                        if (!cap_v[k] && (pos_rts_i[k] || timeout)) begin
                            cap[k]   <= pos_rts_i[k] ? pos_posit_i[k*W +: W] : fill_val;
                            cap_v[k] <= 1'b1;
                        end
                    end
                    if (&cap_v || timeout) begin
                        state  <= EMIT;
                        em_cnt <= '0;
                    end
                end
                EMIT: begin
                    if (rtr_i) begin
                        em_cnt <= em_cnt == LAST_EM ? '0 : em_cnt + IW'(1);
                        state  <= em_cnt == LAST_EM ? IDLE : EMIT;
                        done_o <= em_cnt == LAST_EM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_positron_layer_sequencer.sv
// tb_positron_layer_sequencer: directed self-checking bench for the positron layer sequencer
module tb_positron_layer_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_start = 1'b0, a_busy, a_done, a_rd_en;
    logic [1:0] a_addr;
    logic [3:0] a_data = '0;
    logic       a_prts, a_psow, a_peow, a_prtr_o;
    logic [3:0] a_pposit;
    logic [1:0] a_prtr_i = 2'b11, a_prts_i = 2'b00;
    logic [7:0] a_pposit_i = '0;
    logic       a_rts, a_rtr = 1'b1, a_eow, a_err;
    logic [0:0] a_idx;
    logic [3:0] a_posit;

    logic       b_start = 1'b0, b_busy, b_done, b_rd_en;
    logic [0:0] b_addr;
    logic [3:0] b_data = '0;
    logic       b_prts, b_psow, b_peow, b_prtr_o;
    logic [3:0] b_pposit;
    logic [0:0] b_prtr_i = 1'b1, b_prts_i = 1'b0;
    logic [3:0] b_pposit_i = '0;
    logic       b_rts, b_rtr = 1'b1, b_eow, b_err;
    logic [0:0] b_idx;
    logic [3:0] b_posit;

    positron_layer_sequencer #(.POSIT_WIDTH(4), .NB_UPSTREAM_POSITRON(4), .NB_POSITRON(2), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
        .act_addr_o(a_addr), .act_rd_en_o(a_rd_en), .act_data_i(a_data),
        .pos_rts_o(a_prts), .pos_sow_o(a_psow), .pos_eow_o(a_peow), .pos_posit_o(a_pposit),
        .pos_rtr_i(a_prtr_i), .pos_rtr_o(a_prtr_o), .pos_rts_i(a_prts_i), .pos_posit_i(a_pposit_i),
        .rts_o(a_rts), .rtr_i(a_rtr), .eow_o(a_eow), .index_o(a_idx), .posit_o(a_posit), .error_o(a_err)
    );

    positron_layer_sequencer #(.POSIT_WIDTH(4), .NB_UPSTREAM_POSITRON(1), .NB_POSITRON(1), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
        .act_addr_o(b_addr), .act_rd_en_o(b_rd_en), .act_data_i(b_data),
        .pos_rts_o(b_prts), .pos_sow_o(b_psow), .pos_eow_o(b_peow), .pos_posit_o(b_pposit),
        .pos_rtr_i(b_prtr_i), .pos_rtr_o(b_prtr_o), .pos_rts_i(b_prts_i), .pos_posit_i(b_pposit_i),
        .rts_o(b_rts), .rtr_i(b_rtr), .eow_o(b_eow), .index_o(b_idx), .posit_o(b_posit), .error_o(b_err)
    );

    logic [3:0] mem_a [4];
    initial mem_a = '{4'h1, 4'h2, 4'h3, 4'h4};

    always @(posedge clk) if (a_rd_en) a_data <= mem_a[a_addr];
    always @(posedge clk) if (b_rd_en) b_data <= (b_addr == 1'b0) ? 4'h7 : 4'hF;

    typedef struct {
        logic [3:0] d;
        logic       s;
        logic       e;
        int         c;
    } beat_t;

    beat_t bq[$];
    int    a_dones = 0;
    int    b_beats = 0;

    always @(negedge clk) if (a_prts && (&a_prtr_i)) bq.push_back(beat_t'{a_pposit, a_psow, a_peow, cyc});
    always @(negedge clk) if (a_done) a_dones++;
    always @(negedge clk) if (b_prts && b_prtr_i[0]) b_beats++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(output int n);
        n = 0;
        @(negedge clk);
        while (!a_prtr_o && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("drain_entry", a_prtr_o, 1);
    endtask

    task automatic wait_emit(output int n);
        n = 0;
        @(negedge clk);
        while (!a_rts && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("emit_entry", a_rts, 1);
    endtask

    task automatic stream_frame(input bit stall);
        int c0, n;
        bq.delete();
        c0 = cyc;
        a_start = 1'b1;
        @(negedge clk);
        chk("first_read", {a_rd_en, a_addr}, 3'b100);
        nx();
        a_start = 1'b0;
        if (stall) begin
            nx();
            nx();
            a_prtr_i = 2'b01;
            repeat (3) begin
                @(negedge clk);
                chk("stall_hold", {a_prts, a_pposit}, {1'b1, 4'h2});
                nx();
            end
            a_prtr_i = 2'b11;
        end
        wait_drain(n);
        chk("beat_count", bq.size(), 4);
        for (int i = 0; i < bq.size() && i < 4; i++) begin
            chk("beat_data", bq[i].d, i + 1);
            chk("beat_sow", bq[i].s, i == 0);
            chk("beat_eow", bq[i].e, i == 3);
            chk("beat_cycle", bq[i].c - c0, i + 2 + ((stall && i > 0) ? 3 : 0));
        end
    endtask

    task automatic drain_pair(input logic [3:0] r0, input logic [3:0] r1, input bit same);
        nx();
        if (same) begin
            a_prts_i = 2'b11;
            a_pposit_i = {r1, r0};
        end else begin
            a_prts_i = 2'b01;
            a_pposit_i = {4'h0, r0};
            nx();
            a_prts_i = 2'b11;
            a_pposit_i = {r1, 4'hF};
        end
        nx();
        a_prts_i = 2'b00;
    endtask

    task automatic emit_pair(input logic [3:0] r0, input logic [3:0] r1, input bit hold);
        if (hold) begin
            repeat (2) begin
                chk("emit_hold", {a_rts, a_idx, a_posit}, {1'b1, 1'b0, r0});
                nx();
            end
            a_rtr = 1'b1;
            @(negedge clk);
        end
        chk("emit0", {a_idx, a_eow, a_posit}, {1'b0, 1'b0, r0});
        nx();
        @(negedge clk);
        chk("emit1", {a_rts, a_idx, a_eow, a_posit}, {1'b1, 1'b1, 1'b1, r1});
        nx();
        @(negedge clk);
        chk("emit_end", {a_rts, a_done, a_busy}, 3'b010);
        nx();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        nx();
        nx();
        @(negedge clk);
        chk("rst_a_stream", {a_busy, a_prts, a_psow, a_peow, a_pposit, a_rd_en, a_addr}, 0);
        chk("rst_a_out", {a_prtr_o, a_rts, a_eow, a_idx, a_posit, a_done, a_err}, 0);
        chk("rst_b", {b_busy, b_rd_en, b_prts, b_prtr_o, b_rts, b_posit, b_done, b_err}, 0);
        nx();
        rst = 1'b0;

        stream_frame(1'b0);
        drain_pair(4'h5, 4'h9, 1'b0);
        wait_emit(n);
        emit_pair(4'h5, 4'h9, 1'b0);
        chk("done_count_1", a_dones, 1);

        stream_frame(1'b1);
        drain_pair(4'h3, 4'hC, 1'b1);
        a_rtr = 1'b0;
        wait_emit(n);
        emit_pair(4'h3, 4'hC, 1'b1);
        chk("done_count_2", a_dones, 2);

        a_start = 1'b1;
        nx();
        a_start = 1'b0;
        nx();
        nx();
        rst = 1'b1;
        nx();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid", {a_busy, a_prts, a_psow, a_peow, a_pposit, a_rd_en, a_prtr_o, a_rts, a_done}, 0);
        nx();
        stream_frame(1'b0);
        drain_pair(4'h2, 4'hE, 1'b0);
        wait_emit(n);
        emit_pair(4'h2, 4'hE, 1'b0);
        chk("done_count_3", a_dones, 3);

        stream_frame(1'b0);
        nx();
        a_prts_i = 2'b01;
        a_pposit_i = 8'h05;
        nx();
        a_prts_i = 2'b00;
`ifdef SEQ_TIMEOUT_EN
        wait_emit(n);
        chk("timeout_latency", n, 6);
        chk("timeout_err", a_err, 1);
        emit_pair(4'h5, 4'h8, 1'b0);
        @(negedge clk);
        chk("err_sticky", a_err, 1);
        nx();
`else
        repeat (12) nx();
        @(negedge clk);
        chk("drain_waits", {a_prtr_o, a_rts, a_err}, 3'b100);
        nx();
        a_prts_i = 2'b10;
        a_pposit_i = 8'h90;
        nx();
        a_prts_i = 2'b00;
        wait_emit(n);
        emit_pair(4'h5, 4'h9, 1'b0);
        @(negedge clk);
        chk("err_zero", a_err, 0);
        nx();
`endif
        chk("done_count_4", a_dones, 4);

        b_start = 1'b1;
        nx();
        nx();
        b_start = 1'b0;
        @(negedge clk);
        chk("b_single_beat", {b_prts, b_psow, b_peow, b_pposit}, {3'b111, 4'h7});
        nx();
        b_start = 1'b1;
        b_prts_i = 1'b1;
        b_pposit_i = 4'h6;
        @(negedge clk);
        chk("b_drain", b_prtr_o, 1);
        nx();
        b_start = 1'b0;
        b_prts_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_rts && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("b_emit", {b_rts, b_idx, b_eow, b_posit}, {3'b101, 4'h6});
        nx();
        @(negedge clk);
        chk("b_emit_end", {b_rts, b_done, b_busy}, 3'b010);
        repeat (4) nx();
        @(negedge clk);
        chk("b_no_second", {b_busy, b_rd_en, b_prts}, 0);
        chk("b_beat_total", b_beats, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
